keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad on the FPGA board and produces a debounced 4-bit key value with a one-cycle valid strobe. It is the input end of the digit path: it turns a key press into the same 4-bit number that the seven-segment display logic shows, so an entered digit can be echoed or used as a label. It sits between the board GPIO header and the top-level control logic.

## Interface
- SCAN_CYCLES, 16: clock cycles each column is driven before its rows are sampled; must be ≥ 4.
- DEBOUNCE_COUNT, 4: consecutive identical full-sweep results required to accept a press or a release; must be ≥ 1.
- clk  input  1  system clock.
- n_rst  input  1  reset; asynchronous, active-low.
- row_in  input  4  keypad rows, active-low, pulled up externally; asynchronous to clk.
- col_out  output  4  column drive, active-low, exactly one bit low at all times.
- key_num  output  4  value of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key is considered pressed.

## Operation
- row_in passes through a 2-flop synchronizer; flops reset to 4'hF (no key).
- Column index c cycles 0→1→2→3→0. col_out = ~(1 << c). Dwell counter runs 0..SCAN_CYCLES-1 per column. The synchronized rows are sampled on the dwell count SCAN_CYCLES-1.
- Sweep result at column-3 sample, from the 16 samples: NONE (no low bit), KEY(k) (exactly one low bit, row r, column c, k = 4r+c), or MULTI (two or more low bits). MULTI is treated as NONE in every state.
- Keymap, k→key_num: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E(*),0,F(#),D. Digits 0-9 map to their values, so the display shows 0-9 and blanks the rest.
- FSM, evaluated once per sweep end; cnt is the debounce counter:
  - IDLE: on KEY(k), set cand=k, cnt=1, go to CONFIRM. If DEBOUNCE_COUNT=1, accept immediately instead.
  - CONFIRM: KEY(cand) increments cnt. At cnt=DEBOUNCE_COUNT, go to PRESSED, set key_num=map(cand), pulse key_valid. KEY(j≠cand) restarts with cand=j, cnt=1. NONE returns to IDLE.
  - PRESSED: key_held=1. NONE sets cnt=1 and goes to RELEASE. Any KEY keeps PRESSED. There is no rollover and no auto-repeat.
  - RELEASE: NONE increments cnt. At cnt=DEBOUNCE_COUNT, go to IDLE. Any KEY returns to PRESSED without a pulse. key_held stays 1.
- key_num holds its value until the next accepted key.

## Timing
- Reset values: col_out=4'b1110, key_num=4'h0, key_valid=0, key_held=0, FSM=IDLE, c=0, dwell=0, cnt=0.
- One sweep is 4·SCAN_CYCLES cycles.
- The FSM updates on the edge that samples column 3. key_valid, key_num and key_held are registered, so they change on that edge and key_valid is high for exactly the following cycle.
- Press latency: the press must appear in DEBOUNCE_COUNT consecutive sweeps. The first sweep counts only if the press is stable from at least 2 cycles before that sweep's sample of the key's column.
- key_held falls on the sweep-end edge of the DEBOUNCE_COUNT-th consecutive NONE sweep.
- Asserting n_rst at any point returns all state to reset values immediately. No pending pulse is emitted after reset is released.

## Structure
- Package keypad_pkg holds:
  - the FSM state enum (IDLE, CONFIRM, PRESSED, RELEASE),
  - the 16-entry keymap constant,
  - a sweep-result enum (NONE, KEY, MULTI).
- Sub-module row_sync: 4-bit, 2-flop synchronizer with asynchronous active-low reset to all-ones.
- The counters and FSM live in keypad_scanner.

## Test plan
All scenarios use SCAN_CYCLES=4 and DEBOUNCE_COUNT=3, so one sweep is 16 cycles.
- Reset: n_rst low → col_out=1110, key_num=0, key_valid=0, key_held=0. After release, col_out steps 1110→1101→1011→0111 every 4 cycles.
- Press '5' (row1, col1) and hold 10 sweeps → one key_valid pulse at the 3rd sweep end, key_num=5, key_held=1. On release, key_held falls at the 3rd NONE sweep end, with no second pulse.
- Bounce: '8' pressed one sweep, released one sweep, repeated 5 times → no key_valid, key_held stays 0.
- Hold '1' and '2' together for 4 sweeps → no key_valid. Release '1' → key_valid after 3 more sweeps with key_num=2.
- Press each of the 16 keys in turn → key_num matches the keymap ('*'=E, '0'=0, '#'=F, 'D'=D), with exactly 16 key_valid pulses.
- Reset mid-CONFIRM (press '9', assert n_rst after 2 sweeps for 3 cycles, release with '9' still held) → no pulse during reset. A fresh pulse with key_num=9 arrives 3 full sweeps after reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConfirm = 2'd1,
    StPressed = 2'd2,
    StRelease = 2'd3
  } state_e;

  // Classification of one full four-column sweep.
  typedef enum logic [1:0] {
    SwNone  = 2'd0,
    SwKey   = 2'd1,
    SwMulti = 2'd2
  } sweep_e;

  // Key index k = 4*row + col to displayed value; nibble k sits at bits [4k+3:4k].
  // Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / E(*) 0 F(#) D
  localparam logic [63:0] KeyMap = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] map_key(input logic [3:0] k);
    return KeyMap[{k, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; idles at all-ones (no key).
module row_sync (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  logic [3:0] meta;

  // Shift the raw rows through two flops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= 4'hF;
      dout <= 4'hF;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with sweep-level debounce and one-cycle valid strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES    = 16,
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_num,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DwellW = $clog2(SCAN_CYCLES);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_CYCLES - 1);
  localparam logic [CntW-1:0]   CntTarget = CntW'(DEBOUNCE_COUNT);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);

  logic [3:0] rows_sync;

  row_sync u_row_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .din   (row_in),
    .dout  (rows_sync)
  );

  // Column scan timing.
  logic [1:0]        col_q;
  logic [DwellW-1:0] dwell_q;
  logic              sample;
  logic              sweep_end;

  assign sample    = (dwell_q == DwellLast);
  assign sweep_end = sample && (col_q == 2'd3);
  assign col_out   = ~(4'b0001 << col_q);

  // Advance dwell counter and step to the next column after each sample.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q   <= 2'd0;
      dwell_q <= '0;
    end else if (sample) begin
      col_q   <= col_q + 2'd1;
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + DwellW'(1);
    end
  end

  // hits_q[k] = key k seen pressed at its column's sample this sweep.
  logic [15:0] hits_q;
  logic [15:0] hits_d;

  // Merge the current column's rows into the sweep picture on a sample cycle.
  always_comb begin
    hits_d = hits_q;
    if (sample) begin
      hits_d[{2'd0, col_q}] = ~rows_sync[0];
      hits_d[{2'd1, col_q}] = ~rows_sync[1];
      hits_d[{2'd2, col_q}] = ~rows_sync[2];
      hits_d[{2'd3, col_q}] = ~rows_sync[3];
    end
  end

  // Hold the per-key samples between column samples.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hits_q <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end

  // Sweep classification; the column-3 sample is folded in combinationally via hits_d.
  sweep_e     sweep_res;
  logic [3:0] key_idx;
  logic       key_seen;

  // Encode the index assuming one-hot; only used when exactly one bit is set.
  always_comb begin
    key_idx[0] = |(hits_d & 16'hAAAA);
    key_idx[1] = |(hits_d & 16'hCCCC);
    key_idx[2] = |(hits_d & 16'hF0F0);
    key_idx[3] = |(hits_d & 16'hFF00);
    if (hits_d == 16'h0000) begin
      sweep_res = SwNone;
    end else if ((hits_d & (hits_d - 16'h0001)) != 16'h0000) begin
      sweep_res = SwMulti;
    end else begin
      sweep_res = SwKey;
    end
  end

  // Multiple keys are indistinguishable from no key.
  assign key_seen = (sweep_res == SwKey);

  // Debounce FSM state.
  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      key_num_d;
  logic            key_valid_d;
  logic            key_held_d;

  // Next-state logic, evaluated only on the sweep-end cycle.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_num_d   = key_num;
    key_valid_d = 1'b0;
    if (sweep_end) begin
      unique case (state_q)
        StIdle: begin
          if (key_seen) begin
            cand_d = key_idx;
            if (DEBOUNCE_COUNT == 1) begin
              state_d     = StPressed;
              cnt_d       = '0;
              key_num_d   = map_key(key_idx);
              key_valid_d = 1'b1;
            end else begin
              state_d = StConfirm;
              cnt_d   = CntOne;
            end
          end
        end
        StConfirm: begin
          if (key_seen && (key_idx == cand_q)) begin
            if (cnt_q + CntOne == CntTarget) begin
              state_d     = StPressed;
              cnt_d       = '0;
              key_num_d   = map_key(cand_q);
              key_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else if (key_seen) begin
            cand_d = key_idx;
            cnt_d  = CntOne;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StPressed: begin
          if (!key_seen) begin
            if (DEBOUNCE_COUNT == 1) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              state_d = StRelease;
              cnt_d   = CntOne;
            end
          end
        end
        StRelease: begin
          if (key_seen) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q + CntOne == CntTarget) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
    key_held_d = (state_d == StPressed) || (state_d == StRelease);
  end

  // Register FSM state and the registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      cand_q    <= 4'h0;
      cnt_q     <= '0;
      key_num   <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_num   <= key_num_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: physical keypad model, sweep-level reference model,
// per-cycle comparison plus directed scenarios and randomized key traffic.
module tb_keypad_scanner;

  localparam int S  = 4;
  localparam int DB = 3;
  localparam int SW = 4 * S;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_num;
  logic       key_valid;
  logic       key_held;

  logic [15:0] mask;  // bit 4*row+col set = that key is physically held down

  int tests = 0;
  int fails = 0;
  int dut_pulses = 0;

  keypad_scanner #(
    .SCAN_CYCLES    (S),
    .DEBOUNCE_COUNT (DB)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_num   (key_num),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key connects its column line to its row line.
  logic [1:0] ci;
  logic       ci_ok;
  always_comb begin
    ci    = 2'd0;
    ci_ok = 1'b1;
    case (col_out)
      4'b1110: ci = 2'd0;
      4'b1101: ci = 2'd1;
      4'b1011: ci = 2'd2;
      4'b0111: ci = 2'd3;
      default: ci_ok = 1'b0;
    endcase
    row_in = 4'hF;
    if (ci_ok) begin
      row_in = ~{mask[{2'd3, ci}], mask[{2'd2, ci}], mask[{2'd1, ci}], mask[{2'd0, ci}]};
    end
  end

  // Reference model ------------------------------------------------------------------------
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  int          cyc;
  logic [15:0] seen;
  int          run, nones, cand;
  logic        held;
  logic [3:0]  exp_num;
  logic        exp_valid, exp_held;
  int          model_pulses = 0;

  always @(posedge clk) begin : model
    int pos, c, n, k;
    if (!n_rst) begin
      cyc = 0; seen = '0; run = 0; nones = 0; cand = 0; held = 1'b0;
      exp_num = 4'h0; exp_valid = 1'b0; exp_held = 1'b0;
    end else begin
      pos = cyc % SW;
      c   = pos / S;
      exp_valid = 1'b0;
      if (pos % S == S - 1) begin
        seen = (seen & ~(16'h1111 << c)) | (mask & (16'h1111 << c));
      end
      if (pos == SW - 1) begin
        n = $countones(seen);
        k = 0;
        for (int i = 0; i < 16; i++) if (((seen >> i) & 16'h1) != 16'h0) k = i;
        if (!held) begin
          if (n == 1) begin
            if (run > 0 && k == cand) run++;
            else begin cand = k; run = 1; end
            if (run >= DB) begin
              held = 1'b1; exp_num = kmap[k]; exp_valid = 1'b1;
              run = 0; nones = 0; model_pulses++;
            end
          end else begin
            run = 0;
          end
        end else if (n == 1) begin
          nones = 0;
        end else begin
          nones++;
          if (nones >= DB) begin held = 1'b0; nones = 0; end
        end
        exp_held = held;
      end
      cyc++;
    end
  end

  // Checking helpers ------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, return 2 time units after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (!n_rst) begin
      check("cyc col_out (rst)", 32'(col_out), 32'(4'b1110));
      check("cyc key_num (rst)", 32'(key_num), 32'h0);
      check("cyc key_valid (rst)", 32'(key_valid), 32'h0);
      check("cyc key_held (rst)", 32'(key_held), 32'h0);
    end else begin
      check("cyc col_out", 32'(col_out), 32'(4'b1111 ^ (4'b0001 << ((cyc % SW) / S))));
      check("cyc key_num", 32'(key_num), 32'(exp_num));
      check("cyc key_valid", 32'(key_valid), 32'(exp_valid));
      check("cyc key_held", 32'(key_held), 32'(exp_held));
    end
    if (key_valid === 1'b1) dut_pulses++;
    @(posedge clk);
    #2;
  endtask

  task automatic sweeps(input int n, input logic [15:0] m);
    mask = m;
    repeat (n * SW) step();
  endtask

  task automatic align();
    while (cyc % SW != 0) step();
  endtask

  // Stimulus --------------------------------------------------------------------------------
  int p0;
  logic [15:0] rm;

  initial begin
    n_rst = 1'b0;
    mask  = '0;
    repeat (3) step();
    check("reset col_out", 32'(col_out), 32'(4'b1110));
    check("reset key_num", 32'(key_num), 32'h0);
    check("reset key_valid", 32'(key_valid), 32'h0);
    check("reset key_held", 32'(key_held), 32'h0);
    n_rst = 1'b1;
    repeat (4) step();
    check("scan col1", 32'(col_out), 32'(4'b1101));
    repeat (4) step();
    check("scan col2", 32'(col_out), 32'(4'b1011));
    repeat (4) step();
    check("scan col3", 32'(col_out), 32'(4'b0111));
    repeat (4) step();
    check("scan wrap", 32'(col_out), 32'(4'b1110));

    // Press '5' for 10 sweeps, then release.
    align();
    p0 = dut_pulses;
    sweeps(2, 16'h0020);
    check("5 no early pulse", 32'(dut_pulses - p0), 32'h0);
    sweeps(1, 16'h0020);
    check("5 valid at 3rd sweep", 32'(key_valid), 32'h1);
    check("5 key_num", 32'(key_num), 32'h5);
    check("5 held", 32'(key_held), 32'h1);
    sweeps(7, 16'h0020);
    check("5 single pulse", 32'(dut_pulses - p0), 32'h1);
    sweeps(2, 16'h0000);
    check("5 held after 2 none", 32'(key_held), 32'h1);
    sweeps(1, 16'h0000);
    check("5 released", 32'(key_held), 32'h0);
    check("5 no second pulse", 32'(dut_pulses - p0), 32'h1);

    // Bouncing '8'.
    p0 = dut_pulses;
    repeat (5) begin
      sweeps(1, 16'h0200);
      sweeps(1, 16'h0000);
    end
    check("bounce no pulse", 32'(dut_pulses - p0), 32'h0);
    check("bounce not held", 32'(key_held), 32'h0);

    // '1' and '2' together, then release '1'.
    p0 = dut_pulses;
    sweeps(4, 16'h0003);
    check("multi no pulse", 32'(dut_pulses - p0), 32'h0);
    sweeps(2, 16'h0002);
    check("multi->2 not yet", 32'(key_valid), 32'h0);
    sweeps(1, 16'h0002);
    check("multi->2 valid", 32'(key_valid), 32'h1);
    check("multi->2 key_num", 32'(key_num), 32'h2);
    sweeps(4, 16'h0000);

    // Every key in turn.
    p0 = dut_pulses;
    for (int k = 0; k < 16; k++) begin
      sweeps(4, 16'h0001 << k);
      check($sformatf("keymap k=%0d", k), 32'(key_num), 32'(kmap[k]));
      sweeps(4, 16'h0000);
    end
    check("keymap pulse count", 32'(dut_pulses - p0), 32'd16);
    check("keymap star", 32'(kmap[12]), 32'hE);

    // Reset during CONFIRM with '9' held throughout.
    sweeps(2, 16'h0400);
    n_rst = 1'b0;
    #1;
    check("midrst col_out", 32'(col_out), 32'(4'b1110));
    check("midrst key_num", 32'(key_num), 32'h0);
    check("midrst key_held", 32'(key_held), 32'h0);
    #1;
    p0 = dut_pulses;
    repeat (3) step();
    check("midrst no pulse", 32'(dut_pulses - p0), 32'h0);
    n_rst = 1'b1;
    sweeps(2, 16'h0400);
    check("post-rst not yet", 32'(dut_pulses - p0), 32'h0);
    sweeps(1, 16'h0400);
    check("post-rst valid", 32'(key_valid), 32'h1);
    check("post-rst key_num", 32'(key_num), 32'h9);
    sweeps(4, 16'h0000);

    // Randomized key traffic.
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 3)      rm = 16'h0000;
      else if (kind < 8) rm = 16'h0001 << $urandom_range(0, 15);
      else               rm = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      sweeps($urandom_range(1, 5), rm);
    end
    sweeps(4, 16'h0000);
    check("total pulses", 32'(dut_pulses), 32'(model_pulses));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
